// File: rtl/renode_axi_memory.sv
// AXI4 subordinate RAM with independent write and read engines, one burst in flight per direction.
// Define RENODE_MEM_RANGE_CHECK_EN to answer beats at or above MEM_BYTES with SLVERR instead of wrapping.
module renode_axi_memory #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_BYTES  = 8192
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int NLANES = DATA_WIDTH / 8;
  localparam int WORDS  = MEM_BYTES / NLANES;
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef RENODE_MEM_RANGE_CHECK_EN
  localparam int MEM_AW = $clog2(MEM_BYTES);
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // Byte addresses fold onto the word array modulo MEM_BYTES.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a >> 3) & ADDR_WIDTH'(WORDS - 1));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst);
    if (burst == 2'b00)
      return a;
    return a + (ADDR_WIDTH'(1) << size);
  endfunction

  // Lanes a narrow beat may touch: from the address offset up to the end of its size-aligned container.
  function automatic logic [NLANES-1:0] lane_mask(input logic [2:0] lo_addr, input logic [2:0] size);
    logic [3:0] n, lo, hi;
    logic [NLANES-1:0] m;
    n  = (size > 3'd3) ? 4'd8 : (4'd1 << size);
    lo = {1'b0, lo_addr};
    hi = (lo & ~(n - 4'd1)) + n;
    for (int i = 0; i < NLANES; i++)
      m[i] = (4'(i) >= lo) && (4'(i) < hi);
    return m;
  endfunction

`ifdef RENODE_MEM_RANGE_CHECK_EN
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> MEM_AW) == '0;
  endfunction
`endif

  w_state_e              w_state, w_next;
  logic [ID_WIDTH-1:0]   w_id;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst;
  logic                  w_err;
  logic                  aw_hs, w_hs, w_beat_ok;
  logic [NLANES-1:0]     w_mask;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign w_mask = lane_mask(w_addr[2:0], w_size);
`ifdef RENODE_MEM_RANGE_CHECK_EN
  assign w_beat_ok   = in_range(w_addr);
  assign s_axi_bresp = w_err ? RESP_SLVERR : RESP_OKAY;
`else
  assign w_beat_ok   = 1'b1;
  assign s_axi_bresp = RESP_OKAY;
`endif
  assign s_axi_bid = w_id;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      w_state <= W_IDLE;
    else
      w_state <= w_next;
  end

  // Handshake outputs are held low while reset is asserted.
  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = !rst_i;
        if (s_axi_awvalid)
          w_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = !rst_i;
        if (s_axi_wvalid && (s_axi_wlast || w_cnt == w_len))
          w_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = !rst_i;
        if (s_axi_bready)
          w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_id    <= s_axi_awid;
      w_addr  <= s_axi_awaddr;
      w_len   <= s_axi_awlen;
      w_cnt   <= '0;
      w_size  <= s_axi_awsize;
      w_burst <= s_axi_awburst;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr <= next_addr(w_addr, w_size, w_burst);
      w_cnt  <= w_cnt + 8'd1;
      w_err  <= w_err | !w_beat_ok;
    end
  end

  // Storage has no reset so contents survive an aborted transaction.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NLANES; i++)
      if (w_hs && w_beat_ok && s_axi_wstrb[i] && w_mask[i])
        mem[word_idx(w_addr)][8*i +: 8] <= s_axi_wdata[8*i +: 8];
  end

  r_state_e              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_fetch_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  ar_hs, r_hs, r_fetch_ok;

  assign ar_hs        = s_axi_arvalid && s_axi_arready;
  assign r_hs         = s_axi_rvalid && s_axi_rready;
  assign r_fetch_addr = ar_hs ? s_axi_araddr : next_addr(r_addr, r_size, r_burst);
`ifdef RENODE_MEM_RANGE_CHECK_EN
  assign r_fetch_ok = in_range(r_fetch_addr);
`else
  assign r_fetch_ok = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_state <= R_IDLE;
    else
      r_state <= r_next;
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    s_axi_rlast   = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = !rst_i;
        if (s_axi_arvalid)
          r_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = !rst_i;
        s_axi_rlast  = !rst_i && (r_cnt == r_len);
        if (s_axi_rready && r_cnt == r_len)
          r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Each beat is fetched on the edge that accepts the previous one, so a stalled beat keeps its data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_axi_rid   <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= RESP_OKAY;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
    end else if (ar_hs || (r_hs && r_cnt != r_len)) begin
      if (ar_hs) begin
        s_axi_rid <= s_axi_arid;
        r_len     <= s_axi_arlen;
        r_cnt     <= '0;
        r_size    <= s_axi_arsize;
        r_burst   <= s_axi_arburst;
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
      r_addr      <= r_fetch_addr;
      s_axi_rdata <= r_fetch_ok ? mem[word_idx(r_fetch_addr)] : '0;
`ifdef RENODE_MEM_RANGE_CHECK_EN
      s_axi_rresp <= r_fetch_ok ? RESP_OKAY : RESP_SLVERR;
`else
      s_axi_rresp <= RESP_OKAY;
`endif
    end
  end

endmodule

// File: tb/tb_renode_axi_memory.sv
// Randomised bench for renode_axi_memory against a byte-array reference memory.
// Honours RENODE_MEM_RANGE_CHECK_EN the same way the design does.
module tb_renode_axi_memory;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 64;
  localparam int ID_WIDTH   = 4;
  localparam int MEM_BYTES  = 8192;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen, s_axi_wstrb;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [63:0] s_axi_wdata, s_axi_rdata;

  renode_axi_memory #(
    .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH), .MEM_BYTES(MEM_BYTES)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0]  model_mem [MEM_BYTES];
  logic [63:0] wq_data [256];
  logic [7:0]  wq_strb [256];
  int n_compared = 0;
  int n_mismatched = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit outOfRange(input logic [31:0] a);
`ifdef RENODE_MEM_RANGE_CHECK_EN
    return a >= 32'(MEM_BYTES);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] beatAddr(input logic [31:0] a, input logic [2:0] size,
                                           input logic [1:0] burst, input int k);
    if (burst == 2'b00)
      return a;
    return a + 32'(k) * (32'd1 << size);
  endfunction

  // A beat may only touch bytes from its address to the end of its size-aligned block.
  function automatic void modelWrite(input logic [31:0] a, input logic [2:0] size,
                                     input logic [63:0] d, input logic [7:0] s);
    int n, lo, hi;
    int unsigned base;
    if (outOfRange(a))
      return;
    n    = 1 << size;
    lo   = int'(a[2:0]);
    hi   = (lo / n) * n + n;
    base = a & ~32'd7;
    for (int b = 0; b < 8; b++)
      if (s[b] && b >= lo && b < hi)
        model_mem[(base + 32'(b)) % 32'(MEM_BYTES)] = d[8*b +: 8];
  endfunction

  function automatic logic [63:0] modelRead(input logic [31:0] a);
    logic [63:0] w;
    int unsigned base;
    w = '0;
    if (outOfRange(a))
      return w;
    base = a & ~32'd7;
    for (int b = 0; b < 8; b++)
      w[8*b +: 8] = model_mem[(base + 32'(b)) % 32'(MEM_BYTES)];
    return w;
  endfunction

  task automatic axiWrite(input logic [31:0] a, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input bit gaps);
    bit err;
    int waitc, stall;
    err = 0;
    checkOutput("awready_idle", s_axi_awready, 1);
    s_axi_awvalid = 1; s_axi_awid = id; s_axi_awaddr = a; s_axi_awlen = 8'(len);
    s_axi_awsize = size; s_axi_awburst = burst;
    tick();
    s_axi_awvalid = 0;
    checkOutput("awready_busy", s_axi_awready, 0);
    checkOutput("wready_latency", s_axi_wready, 1);
    for (int k = 0; k <= len; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axi_wvalid = 0;
        tick();
      end
      s_axi_wvalid = 1; s_axi_wdata = wq_data[k]; s_axi_wstrb = wq_strb[k]; s_axi_wlast = (k == len);
      if (s_axi_wready) begin
        if (outOfRange(beatAddr(a, size, burst, k)))
          err = 1;
        modelWrite(beatAddr(a, size, burst, k), size, wq_data[k], wq_strb[k]);
      end else begin
        checkOutput("wready_beat", s_axi_wready, 1);
      end
      tick();
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
    checkOutput("bvalid_latency", s_axi_bvalid, 1);
    waitc = 0;
    while (!s_axi_bvalid && waitc < 20) begin
      tick();
      waitc++;
    end
    stall = $urandom_range(0, 2);
    for (int i = 0; i < stall; i++) begin
      tick();
      checkOutput("bvalid_hold", s_axi_bvalid, 1);
      checkOutput("bid_hold", s_axi_bid, id);
    end
    checkOutput("bid", s_axi_bid, id);
    checkOutput("bresp", s_axi_bresp, err ? 2'b10 : 2'b00);
    s_axi_bready = 1;
    tick();
    s_axi_bready = 0;
    checkOutput("bvalid_clear", s_axi_bvalid, 0);
  endtask

  task automatic axiRead(input logic [31:0] a, input int len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id, input bit stall_en);
    logic [63:0] held_d;
    logic held_l;
    bit stalled;
    int k, guard;
    held_d = '0; held_l = 0;
    checkOutput("arready_idle", s_axi_arready, 1);
    s_axi_arvalid = 1; s_axi_arid = id; s_axi_araddr = a; s_axi_arlen = 8'(len);
    s_axi_arsize = size; s_axi_arburst = burst;
    tick();
    s_axi_arvalid = 0;
    checkOutput("rvalid_latency", s_axi_rvalid, 1);
    checkOutput("arready_busy", s_axi_arready, 0);
    k = 0; guard = 0; stalled = 0;
    while (k <= len && guard < 8 * (len + 1) + 20) begin
      s_axi_rready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_axi_rvalid) begin
        if (stalled) begin
          checkOutput("rdata_hold", s_axi_rdata, held_d);
          checkOutput("rlast_hold", s_axi_rlast, held_l);
        end
        checkOutput("rlast", s_axi_rlast, k == len);
        if (s_axi_rready) begin
          checkOutput("rdata", s_axi_rdata, modelRead(beatAddr(a, size, burst, k)));
          checkOutput("rresp", s_axi_rresp, outOfRange(beatAddr(a, size, burst, k)) ? 2'b10 : 2'b00);
          checkOutput("rid", s_axi_rid, id);
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
          held_d  = s_axi_rdata;
          held_l  = s_axi_rlast;
        end
      end
      tick();
      guard++;
    end
    s_axi_rready = 0;
    checkOutput("r_beat_count", k, len + 1);
    checkOutput("rvalid_clear", s_axi_rvalid, 0);
  endtask

  // Each round writes a random burst and reads the same burst back.
  task automatic applyStimulus(input int rounds);
    logic [31:0] a;
    logic [2:0] size;
    logic [1:0] burst;
    int len, n, limit;
    limit = MEM_BYTES;
`ifdef RENODE_MEM_RANGE_CHECK_EN
    limit = 2 * MEM_BYTES;
`endif
    for (int r = 0; r < rounds; r++) begin
      size  = 3'($urandom_range(0, 3));
      burst = 2'($urandom_range(0, 2));
      len   = $urandom_range(0, 7);
      n     = 1 << size;
      a     = 32'($urandom_range(0, limit - 1)) & ~(32'(n) - 32'd1);
      for (int k = 0; k <= len; k++) begin
        wq_data[k] = {$urandom, $urandom};
        wq_strb[k] = 8'($urandom_range(0, 255));
      end
      axiWrite(a, len, size, burst, 4'($urandom_range(0, 15)), 1);
      axiRead(a, len, size, burst, 4'($urandom_range(0, 15)), 1);
    end
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < MEM_BYTES; i++) model_mem[i] = 8'h00;
    rst_i = 1;
    s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
    s_axi_awvalid = 0; s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0; s_axi_wvalid = 0;
    s_axi_bready = 0; s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0;
    s_axi_arburst = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    repeat (3) tick();
    checkOutput("rst_awready", s_axi_awready, 0);
    checkOutput("rst_wready", s_axi_wready, 0);
    checkOutput("rst_bvalid", s_axi_bvalid, 0);
    checkOutput("rst_arready", s_axi_arready, 0);
    checkOutput("rst_rvalid", s_axi_rvalid, 0);
    checkOutput("rst_rlast", s_axi_rlast, 0);
    checkOutput("rst_bid", s_axi_bid, 0);
    checkOutput("rst_bresp", s_axi_bresp, 0);
    checkOutput("rst_rid", s_axi_rid, 0);
    checkOutput("rst_rresp", s_axi_rresp, 0);
    checkOutput("rst_rdata", s_axi_rdata, 0);
    rst_i = 0;
    tick();
    checkOutput("post_rst_awready", s_axi_awready, 1);
    checkOutput("post_rst_arready", s_axi_arready, 1);

    $display("[TB] single-beat read after reset");
    axiRead(32'h10, 0, 3'd2, 2'b01, 4'h3, 0);

    $display("[TB] clearing memory with 256-beat bursts");
    for (int k = 0; k < 256; k++) begin
      wq_data[k] = '0;
      wq_strb[k] = 8'hFF;
    end
    for (int blk = 0; blk < MEM_BYTES / 2048; blk++)
      axiWrite(32'(blk * 2048), 255, 3'd3, 2'b01, 4'(blk), 0);

    $display("[TB] word and quadword round trips");
    wq_data[0] = 64'h100; wq_strb[0] = 8'h0F;
    axiWrite(32'h10, 0, 3'd2, 2'b01, 4'h1, 0);
    axiRead(32'h10, 0, 3'd2, 2'b01, 4'h2, 0);
    checkOutput("word_roundtrip", s_axi_rdata, 64'h100);
    wq_data[0] = 64'h200; wq_strb[0] = 8'hFF;
    axiWrite(32'h1000, 0, 3'd3, 2'b01, 4'h5, 0);
    axiRead(32'h1000, 0, 3'd3, 2'b01, 4'h6, 0);
    checkOutput("qword_roundtrip", s_axi_rdata, 64'h200);

    $display("[TB] 4-beat INCR burst with rready toggling");
    for (int k = 0; k < 4; k++) begin
      wq_data[k] = 64'(k + 1);
      wq_strb[k] = 8'hFF;
    end
    axiWrite(32'h20, 3, 3'd3, 2'b01, 4'h7, 1);
    axiRead(32'h20, 3, 3'd3, 2'b01, 4'h8, 1);

    $display("[TB] FIXED burst and access beyond MEM_BYTES");
    for (int k = 0; k < 3; k++) begin
      wq_data[k] = {$urandom, $urandom};
      wq_strb[k] = 8'hFF;
    end
    axiWrite(32'h40, 2, 3'd3, 2'b00, 4'h9, 0);
    axiRead(32'h40, 0, 3'd3, 2'b01, 4'hA, 0);
    wq_data[0] = 64'hDEAD_BEEF_CAFE_F00D; wq_strb[0] = 8'hFF;
    axiWrite(32'h2000, 0, 3'd3, 2'b01, 4'hB, 0);
    axiRead(32'h0, 0, 3'd3, 2'b01, 4'hC, 0);
    axiRead(32'h2000, 0, 3'd3, 2'b01, 4'hD, 0);

    $display("[TB] reset in the middle of a write burst");
    checkOutput("awready_idle", s_axi_awready, 1);
    s_axi_awvalid = 1; s_axi_awid = 4'hE; s_axi_awaddr = 32'h80; s_axi_awlen = 8'd3;
    s_axi_awsize = 3'd3; s_axi_awburst = 2'b01;
    tick();
    s_axi_awvalid = 0;
    for (int k = 0; k < 2; k++) begin
      s_axi_wvalid = 1; s_axi_wdata = {$urandom, $urandom}; s_axi_wstrb = 8'hFF; s_axi_wlast = 0;
      if (s_axi_wready)
        modelWrite(32'h80 + 32'(8 * k), 3'd3, s_axi_wdata, 8'hFF);
      else
        checkOutput("abort_wready", s_axi_wready, 1);
      tick();
    end
    s_axi_wvalid = 0;
    rst_i = 1;
    tick();
    checkOutput("abort_bvalid", s_axi_bvalid, 0);
    checkOutput("abort_awready_rst", s_axi_awready, 0);
    checkOutput("abort_wready_rst", s_axi_wready, 0);
    rst_i = 0;
    tick();
    checkOutput("abort_awready", s_axi_awready, 1);
    checkOutput("abort_bvalid_after", s_axi_bvalid, 0);
    axiRead(32'h80, 3, 3'd3, 2'b01, 4'h1, 0);
    wq_data[0] = 64'h0123_4567_89AB_CDEF; wq_strb[0] = 8'hFF;
    axiWrite(32'h80, 0, 3'd3, 2'b01, 4'h2, 0);
    axiRead(32'h80, 0, 3'd3, 2'b01, 4'h3, 0);

    $display("[TB] randomised write/read rounds");
    applyStimulus(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
